// File: rtl/config_stream_decoder_pkg.sv
// Shared config-bus widths, payload types and register offsets for the
// config stream decoder.
package config_stream_decoder_pkg;

  localparam int AXI_ADDR_BITS  = 32;
  localparam int AXIL_DATA_BITS = 64;

  typedef logic [7:0] type_t;

  typedef struct packed {
    logic [63:0] vaddr;
    logic [31:0] size;
  } buffer_t;

  // Byte offsets from ADDR_BASE, one 8-byte slot per register.
  localparam logic [AXI_ADDR_BITS-1:0] REG_IN_SELECT  = 'h00;
  localparam logic [AXI_ADDR_BITS-1:0] REG_OUT_SELECT = 'h08;
  localparam logic [AXI_ADDR_BITS-1:0] REG_TYPE       = 'h10;
  localparam logic [AXI_ADDR_BITS-1:0] REG_VADDR      = 'h18;
  localparam logic [AXI_ADDR_BITS-1:0] REG_SIZE       = 'h20;
  localparam logic [AXI_ADDR_BITS-1:0] REG_ERR_CLEAR  = 'h28;

endpackage

// File: rtl/config_stream_decoder_if.sv
// Config write bus (no backpressure) and a generic ready/valid channel.
interface config_i;
  logic                                                 valid;
  logic [config_stream_decoder_pkg::AXI_ADDR_BITS-1:0]  addr;
  logic [config_stream_decoder_pkg::AXIL_DATA_BITS-1:0] data;

  modport s (input valid, addr, data);
  modport m (output valid, addr, data);
endinterface

interface ready_valid_i #(
  parameter int W = 1
);
  logic         valid;
  logic         ready;
  logic [W-1:0] data;

  modport m (output valid, data, input ready);
  modport s (input valid, data, output ready);
endinterface

// File: rtl/config_stream_decoder_fifo.sv
// Registered-head FIFO for one decoder output channel; a push into a full
// FIFO is dropped unless a pop frees a slot in the same cycle.
module config_fifo #(
  parameter type T     = logic,
  parameter int  DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  T     push_data,
  input  logic ready,
  output logic valid,
  output T     head,
  output logic drop
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  T              mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_next;
  logic          full;
  logic          pop;
  logic          accept;

  assign full   = (count == CW'(DEPTH));
  assign valid  = (count != '0);
  assign pop    = valid && ready;
  assign accept = push && (!full || pop);
  assign drop   = push && full && !pop;
  assign head   = mem[rd_ptr];

  always_comb begin
    // NOTE: default first so every path assigns count_next; no latch.
    count_next = count;
    unique case ({accept, pop})
      2'b10:   count_next = count + CW'(1);
      2'b01:   count_next = count - CW'(1);
      default: count_next = count;
    endcase
  end

  // NOTE: non-blocking assignments in clocked logic so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + PW'(1);
      if (pop)    rd_ptr <= rd_ptr + PW'(1);
      count <= count_next;
    end
  end

  // NOTE: storage is deliberately not reset; the count alone defines which
  // entries are live, so stale contents are never presented as valid.
  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/config_stream_decoder.sv
// Decodes config-bus writes into four queued ready/valid channels with sticky
// drop flags. The stream-type channel is named stream_type; `type` is reserved.
module config_stream_decoder
  import config_stream_decoder_pkg::*;
#(
  parameter logic [AXI_ADDR_BITS-1:0] ADDR_BASE    = '0,
  parameter int                       SELECT_WIDTH = 4,
  parameter int                       FIFO_DEPTH   = 4
) (
  input  logic         clk,
  input  logic         rst,
  config_i.s           cfg,
  ready_valid_i.m      in_select,
  ready_valid_i.m      out_select,
  ready_valid_i.m      stream_type,
  ready_valid_i.m      buffer,
  output logic [3:0]   err
);

  logic [AXI_ADDR_BITS-1:0] offset;
  logic                     wr;
  logic                     hit_in, hit_out, hit_type, hit_vaddr, hit_size, hit_clr;
  logic                     push_buf, size_orphan;
  logic [63:0]              vaddr_q;
  logic                     vaddr_pending;
  buffer_t                  buf_push_data;
  logic [3:0]               err_set, err_clr;

  logic [SELECT_WIDTH-1:0]  sel_data, in_head, out_head;
  type_t                    type_data, type_head;
  buffer_t                  buf_head;
  logic                     in_valid, out_valid, type_valid, buf_valid;
  logic                     in_drop, out_drop, type_drop, buf_drop;

  // A write coincident with reset is discarded outright.
  assign wr        = cfg.valid && !rst;
  assign offset    = cfg.addr - ADDR_BASE;
  assign hit_in    = wr && (offset == REG_IN_SELECT);
  assign hit_out   = wr && (offset == REG_OUT_SELECT);
  assign hit_type  = wr && (offset == REG_TYPE);
  assign hit_vaddr = wr && (offset == REG_VADDR);
  assign hit_size  = wr && (offset == REG_SIZE);
  assign hit_clr   = wr && (offset == REG_ERR_CLEAR);

  assign push_buf    = hit_size && vaddr_pending;
  assign size_orphan = hit_size && !vaddr_pending;

  assign sel_data      = cfg.data[SELECT_WIDTH-1:0];
  assign type_data     = type_t'(cfg.data[$bits(type_t)-1:0]);
  assign buf_push_data = '{vaddr: vaddr_q, size: cfg.data[31:0]};

  assign err_set = {buf_drop | size_orphan, type_drop, out_drop, in_drop};
  assign err_clr = hit_clr ? cfg.data[3:0] : 4'b0000;

  always_ff @(posedge clk) begin
    if (rst) begin
      vaddr_q       <= '0;
      vaddr_pending <= 1'b0;
      err           <= '0;
    end else begin
      if (hit_vaddr) begin
        vaddr_q       <= cfg.data[63:0];
        vaddr_pending <= 1'b1;
      end else if (hit_size) begin
        vaddr_pending <= 1'b0;
      end
      // Set wins over clear when both land in the same cycle.
      err <= (err & ~err_clr) | err_set;
    end
  end

  config_fifo #(.T(logic [SELECT_WIDTH-1:0]), .DEPTH(FIFO_DEPTH)) u_in_fifo (
    .clk(clk), .rst(rst), .push(hit_in), .push_data(sel_data),
    .ready(in_select.ready), .valid(in_valid), .head(in_head), .drop(in_drop)
  );

  config_fifo #(.T(logic [SELECT_WIDTH-1:0]), .DEPTH(FIFO_DEPTH)) u_out_fifo (
    .clk(clk), .rst(rst), .push(hit_out), .push_data(sel_data),
    .ready(out_select.ready), .valid(out_valid), .head(out_head), .drop(out_drop)
  );

  config_fifo #(.T(type_t), .DEPTH(FIFO_DEPTH)) u_type_fifo (
    .clk(clk), .rst(rst), .push(hit_type), .push_data(type_data),
    .ready(stream_type.ready), .valid(type_valid), .head(type_head), .drop(type_drop)
  );

  config_fifo #(.T(buffer_t), .DEPTH(FIFO_DEPTH)) u_buf_fifo (
    .clk(clk), .rst(rst), .push(push_buf), .push_data(buf_push_data),
    .ready(buffer.ready), .valid(buf_valid), .head(buf_head), .drop(buf_drop)
  );

  assign in_select.valid   = in_valid;
  assign in_select.data    = in_head;
  assign out_select.valid  = out_valid;
  assign out_select.data   = out_head;
  assign stream_type.valid = type_valid;
  assign stream_type.data  = type_head;
  assign buffer.valid      = buf_valid;
  assign buffer.data       = buf_head;

endmodule

// File: tb/tb_config_stream_decoder.sv
// Directed bench for config_stream_decoder: decode, staging, overflow,
// simultaneous pop/push, error clear and reset behaviour.
module tb_config_stream_decoder;
  import config_stream_decoder_pkg::*;

  localparam logic [AXI_ADDR_BITS-1:0] BASE = 'h100;
  localparam int SW = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] err;
  int         n_cmp = 0;
  int         n_err = 0;

  config_i                            cfg_if ();
  ready_valid_i #(.W(SW))             in_if ();
  ready_valid_i #(.W(SW))             out_if ();
  ready_valid_i #(.W($bits(type_t)))  type_if ();
  ready_valid_i #(.W($bits(buffer_t))) buf_if ();

  config_stream_decoder #(.ADDR_BASE(BASE), .SELECT_WIDTH(SW), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .cfg(cfg_if), .in_select(in_if), .out_select(out_if),
    .stream_type(type_if), .buffer(buf_if), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One write occupies exactly one rising edge; returns on the next falling edge.
  task automatic cfg_write(input logic [AXI_ADDR_BITS-1:0] off, input logic [63:0] d);
    @(negedge clk);
    cfg_if.valid = 1'b1;
    cfg_if.addr  = BASE + off;
    cfg_if.data  = d;
    @(negedge clk);
    cfg_if.valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    cfg_if.valid = 1'b0; cfg_if.addr = '0; cfg_if.data = '0;
    in_if.ready = 1'b0; out_if.ready = 1'b0; type_if.ready = 1'b0; buf_if.ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    check("reset_valids", {in_if.valid, out_if.valid, type_if.valid, buf_if.valid}, 4'b0000);
    check("reset_err", err, 4'b0000);

    // out_select single beat, one-cycle latency
    out_if.ready = 1'b1;
    cfg_write('h08, 64'h5);
    check("out_valid", out_if.valid, 1'b1);
    check("out_data", out_if.data, 4'h5);
    check("out_err", err, 4'b0000);
    @(negedge clk);
    check("out_one_beat", out_if.valid, 1'b0);
    out_if.ready = 1'b0;

    // unmapped address has no effect
    cfg_write('h30, 64'hF);
    check("unmapped_valids", {in_if.valid, out_if.valid, type_if.valid, buf_if.valid}, 4'b0000);
    check("unmapped_err", err, 4'b0000);

    // buffer staging then commit
    cfg_write('h18, 64'h1000);
    check("vaddr_staging_only", buf_if.valid, 1'b0);
    cfg_write('h20, 64'h40);
    check("buf_valid", buf_if.valid, 1'b1);
    check("buf_data", buf_if.data, {64'h1000, 32'h40});
    buf_if.ready = 1'b1;
    @(negedge clk);
    check("buf_one_beat", buf_if.valid, 1'b0);
    buf_if.ready = 1'b0;

    // last vaddr wins, no error
    cfg_write('h18, 64'hAAAA);
    cfg_write('h18, 64'h2000);
    cfg_write('h20, 64'hFFFF_FFFF_0000_0080);
    check("vaddr_overwrite_data", buf_if.data, {64'h2000, 32'h80});
    check("vaddr_overwrite_err", err, 4'b0000);
    buf_if.ready = 1'b1;
    @(negedge clk);
    buf_if.ready = 1'b0;

    // size write without staged vaddr (pending cleared by last commit)
    cfg_write('h20, 64'h99);
    check("orphan_no_beat", buf_if.valid, 1'b0);
    check("orphan_err", err, 4'b1000);
    cfg_write('h28, 64'hF);
    check("clear_all", err, 4'b0000);

    // type overflow: fifth write dropped
    for (int i = 1; i <= 4; i++) cfg_write('h10, 64'(i));
    check("type_full_no_err", err, 4'b0000);
    cfg_write('h10, 64'h5);
    check("type_overflow_err", err, 4'b0100);
    type_if.ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      check("type_drain_valid", type_if.valid, 1'b1);
      check("type_drain_data", type_if.data, 8'(i));
      @(negedge clk);
    end
    check("type_drained", type_if.valid, 1'b0);
    type_if.ready = 1'b0;

    // selective clear
    cfg_write('h20, 64'h1);
    check("two_flags", err, 4'b1100);
    cfg_write('h28, 64'h4);
    check("clear_bit2_only", err, 4'b1000);
    cfg_write('h28, 64'h8);
    check("clear_bit3", err, 4'b0000);

    // full in_select, pop and push in the same cycle
    for (int i = 1; i <= 4; i++) cfg_write('h00, 64'(i));
    @(negedge clk);
    in_if.ready  = 1'b1;
    cfg_if.valid = 1'b1;
    cfg_if.addr  = BASE + 'h00;
    cfg_if.data  = 64'h9;
    @(negedge clk);
    cfg_if.valid = 1'b0;
    check("popush_err", err, 4'b0000);
    check("popush_head", in_if.data, 4'h2);
    @(negedge clk);
    check("popush_d3", in_if.data, 4'h3);
    @(negedge clk);
    check("popush_d4", in_if.data, 4'h4);
    @(negedge clk);
    check("popush_last9", in_if.data, 4'h9);
    check("popush_last_valid", in_if.valid, 1'b1);
    @(negedge clk);
    check("popush_drained", in_if.valid, 1'b0);
    in_if.ready = 1'b0;

    // reset mid-operation, with a coincident write
    cfg_write('h20, 64'h1);
    cfg_write('h00, 64'hA);
    cfg_write('h08, 64'hB);
    cfg_write('h10, 64'hC);
    cfg_write('h18, 64'h5000);
    check("pre_reset_valids", {in_if.valid, out_if.valid, type_if.valid}, 3'b111);
    check("pre_reset_err", err, 4'b1000);
    @(negedge clk);
    rst = 1'b1;
    cfg_if.valid = 1'b1;
    cfg_if.addr  = BASE + 'h00;
    cfg_if.data  = 64'h3;
    @(negedge clk);
    rst = 1'b0;
    cfg_if.valid = 1'b0;
    check("post_reset_valids", {in_if.valid, out_if.valid, type_if.valid, buf_if.valid}, 4'b0000);
    check("post_reset_err", err, 4'b0000);
    cfg_write('h20, 64'h10);
    check("pending_cleared_no_beat", buf_if.valid, 1'b0);
    check("pending_cleared_err", err, 4'b1000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
